// File: rtl/line_window_3x3_pkg.sv
// Package win_pkg: shared definitions for the 3x3 line-window generator.
//   PAD_ZERO / PAD_REPL : pad-mode encodings (zero pad / replicate edge)
//   state_t             : sequencing states RUN / EOL / TAIL
//   tap_t               : window tap indices, row-major from top-left (W_CC = centre)
package win_pkg;

    localparam bit PAD_ZERO = 1'b0;
    localparam bit PAD_REPL = 1'b1;

    typedef enum logic [1:0] {
        RUN,
        EOL,
        TAIL
    } state_t;

    typedef enum int unsigned {
        W_TL = 0,
        W_TC = 1,
        W_TR = 2,
        W_CL = 3,
        W_CC = 4,
        W_CR = 5,
        W_BL = 6,
        W_BC = 7,
        W_BR = 8
    } tap_t;

endpackage

// File: rtl/line_window_3x3_line_buffer.sv
// line_buffer: one image line of storage, 1 write port + 1 read port.
//   clk      clock
//   i_we     write enable
//   i_waddr  write address (column)
//   i_wdata  write data
//   i_raddr  read address (column)
//   o_rdata  read data
// Writes are clocked; the read is combinational, so a read and a write to the
// same address in one cycle return the old contents (read-before-write).
module line_buffer #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/line_window_3x3.sv
// line_window_3x3: streaming 3x3 neighbourhood generator with internal border padding.
// One 9-tap window is emitted per input pixel (same-size output).
//   clk        clock
//   rst_n      synchronous active-low reset
//   pad_mode   0 zero pad / 1 replicate edge; captured at the first pixel of a frame
//   in_valid   in_pixel valid
//   in_ready   pixel accepted this cycle when in_valid is high
//   in_pixel   raster pixel, row-major
//   out_valid  window valid
//   out_ready  downstream accepts window
//   out_win    taps w0..w8 row-major from top-left, w0 at LSBs, w4 = centre
//   out_eol    window is the last column of its row
//   out_eof    window is the last of the frame
module line_window_3x3
    import win_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter bit PAD_DEF = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pad_mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_pixel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [9*DATA_W-1:0] out_win,
    output logic                out_eol,
    output logic                out_eof
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam int AW = $clog2(IMG_W);

    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] C_END  = CW'(IMG_W);
    localparam logic [CW-1:0] C_TWO  = CW'(2);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] R_END  = RW'(IMG_H);
    localparam logic [RW-1:0] R_TWO  = RW'(2);

    state_t              r_state;
    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic                r_pad;
    logic [DATA_W-1:0]   r_tap [3][3];
    logic                r_out_valid;
    logic [9*DATA_W-1:0] r_out_win;
    logic                r_out_eol;
    logic                r_out_eof;

    logic                w_adv;
    logic                w_accept;
    logic                w_step;
    logic                w_emit;
    logic [AW-1:0]       w_addr;
    logic [DATA_W-1:0]   w_lb0_rd;
    logic [DATA_W-1:0]   w_lb1_rd;
    logic [DATA_W-1:0]   w_new [3];
    logic [DATA_W-1:0]   w_win [3][3];
    logic [2:0]          w_row_ok;
    logic [2:0]          w_col_ok;
    logic [9*DATA_W-1:0] w_pad_win;

    // Every step (real or synthetic) advances the whole pipeline; nothing moves
    // while a window is held under backpressure.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = rst_n && (r_state == RUN) && w_adv;
    assign w_accept = in_ready && in_valid;
    assign w_step   = (r_state == RUN) ? w_accept : (w_adv && rst_n);
    assign w_emit   = (r_row != '0) && (r_col != '0);

    // Synthetic columns (col == IMG_W) read an arbitrary entry; that column is always padded.
    assign w_addr = (r_col < C_END) ? r_col[AW-1:0] : '0;

    // lb0 holds the previous row, lb1 the row before it. On each pixel lb0's old
    // entry cascades into lb1 at the same column.
    line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(AW)) u_lb0 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (w_addr),
        .i_wdata (in_pixel),
        .i_raddr (w_addr),
        .o_rdata (w_lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(AW)) u_lb1 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (w_addr),
        .i_wdata (w_lb0_rd),
        .i_raddr (w_addr),
        .o_rdata (w_lb1_rd)
    );

    // Window as it stands after this step: two older columns plus the incoming one.
    always_comb begin
        w_new[0] = w_lb1_rd;
        w_new[1] = w_lb0_rd;
        w_new[2] = in_pixel;
        for (int unsigned i = 0; i < 3; i++) begin
            w_win[i][0] = r_tap[i][1];
            w_win[i][1] = r_tap[i][2];
            w_win[i][2] = w_new[i];
        end
    end

    // Step (r,c) centres on (r-1,c-1): the top row/left column exist when r,c >= 2,
    // the bottom row/right column when r < IMG_H, c < IMG_W. Replicate mode
    // substitutes the centre row/column for a missing one, clamping each axis alone.
    always_comb begin
        w_row_ok  = {r_row < R_END, 1'b1, r_row >= R_TWO};
        w_col_ok  = {r_col < C_END, 1'b1, r_col >= C_TWO};
        w_pad_win = '0;
        for (int unsigned k = W_TL; k <= W_BR; k++) begin
            int unsigned ti;
            int unsigned tj;
            int unsigned si;
            int unsigned sj;
            ti = k / 3;
            tj = k % 3;
            si = w_row_ok[ti] ? ti : 32'd1;
            sj = w_col_ok[tj] ? tj : 32'd1;
            if (r_pad == PAD_ZERO) begin
                w_pad_win[k*DATA_W +: DATA_W] = (w_row_ok[ti] && w_col_ok[tj]) ? w_win[ti][tj] : '0;
            end else begin
                w_pad_win[k*DATA_W +: DATA_W] = w_win[si][sj];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_step) begin
            for (int unsigned i = 0; i < 3; i++) begin
                for (int unsigned j = 0; j < 3; j++) begin
                    r_tap[i][j] <= w_win[i][j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_row       <= '0;
            r_col       <= '0;
            r_pad       <= PAD_DEF;
            r_out_valid <= 1'b0;
            r_out_win   <= '0;
            r_out_eol   <= 1'b0;
            r_out_eof   <= 1'b0;
        end else begin
            if (w_accept && (r_row == '0) && (r_col == '0)) begin
                r_pad <= pad_mode ? PAD_REPL : PAD_ZERO;
            end
            if (w_adv) begin
                r_out_valid <= w_step && w_emit;
            end
            if (w_step) begin
                if (w_emit) begin
                    r_out_win <= w_pad_win;
                    r_out_eol <= (r_col == C_END);
                    r_out_eof <= (r_col == C_END) && (r_row == R_END);
                end
                case (r_state)
                    RUN: begin
                        if (r_col == C_LAST) begin
                            r_col   <= C_END;
                            r_state <= EOL;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                    EOL: begin
                        r_col <= '0;
                        if (r_row == R_LAST) begin
                            r_row   <= R_END;
                            r_state <= TAIL;
                        end else begin
                            r_row   <= r_row + 1'b1;
                            r_state <= RUN;
                        end
                    end
                    TAIL: begin
                        if (r_col == C_END) begin
                            r_col   <= '0;
                            r_row   <= '0;
                            r_state <= RUN;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= RUN;
                    end
                endcase
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_win   = r_out_win;
    assign out_eol   = r_out_eol;
    assign out_eof   = r_out_eof;

endmodule
